// File: rtl/keccak_sponge_ctrl.sv
// Host-side sponge sequencer for the masked keccak1600 core: absorbs a two-share
// word stream with SHA-3 padding on share 0, permutes per rate block, streams the digest.
module keccak_sponge_ctrl #(
  parameter int          RATE_WORDS = 34,
  parameter int          OUT_WORDS  = 8,
  parameter logic [7:0]  DOMAIN     = 8'h06
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data_0,
  input  logic [31:0] in_data_1,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data_0,
  output logic [31:0] out_data_1,
  output logic        out_last,
  output logic        busy,
  output logic        core_init,
  output logic        core_go,
  output logic        core_absorb,
  output logic        core_squeeze,
  output logic        core_extend,
  output logic [31:0] core_din_0,
  output logic [31:0] core_din_1,
  input  logic        core_done,
  input  logic [31:0] core_result_0,
  input  logic [31:0] core_result_1
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ABSORB, S_PAD, S_ROTATE, S_GO, S_WAIT, S_SQUEEZE
  } state_t;

  localparam logic [5:0] RATE_LAST = 6'(RATE_WORDS - 1);
  localparam logic [5:0] ROT_LAST  = 6'd49;
  localparam logic [5:0] OUT_LAST  = 6'(OUT_WORDS - 1);

  // Handshakes: a word moves on any cycle where valid && ready are both high at
  // the rising clock edge; valid never waits for ready, ready depends only on state.
  state_t      state, state_nxt;
  logic [5:0]  wc, oc;
  logic        msg_done, pad_started, pad_done;
  logic        in_hs, out_hs, wc_last, short_last;
  logic [31:0] pad_mask;

  assign in_hs      = (state == S_ABSORB) && in_valid;
  assign out_hs     = (state == S_SQUEEZE) && out_ready;
  assign wc_last    = (wc == RATE_LAST);
  assign short_last = in_last && (in_bytes < 3'd4);

  // Padding merged into the final partial word; 0x80 joins it only in the last rate word.
  always_comb begin
    pad_mask = '0;
    if (short_last) begin
      pad_mask = {24'h0, DOMAIN} << {in_bytes[1:0], 3'b000};
      if (wc_last) pad_mask = pad_mask | 32'h8000_0000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (in_valid) state_nxt = S_INIT;
      S_INIT:    state_nxt = S_ABSORB;
      S_ABSORB:  if (in_hs) begin
                   if (wc_last)      state_nxt = S_ROTATE;
                   else if (in_last) state_nxt = S_PAD;
                 end
      S_PAD:     if (wc_last) state_nxt = S_ROTATE;
      S_ROTATE:  if (wc == ROT_LAST) state_nxt = S_GO;
      S_GO:      state_nxt = S_WAIT;
      S_WAIT:    if (core_done) begin
                   if (pad_done)      state_nxt = S_SQUEEZE;
                   else if (msg_done) state_nxt = S_PAD;
                   else               state_nxt = S_ABSORB;
                 end
      S_SQUEEZE: if (out_hs && (oc == OUT_LAST)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // wc keeps counting through ROTATE so the rotate length is 50 - RATE_WORDS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wc          <= '0;
      oc          <= '0;
      msg_done    <= 1'b0;
      pad_started <= 1'b0;
      pad_done    <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          wc          <= '0;
          oc          <= '0;
          msg_done    <= 1'b0;
          pad_started <= 1'b0;
          pad_done    <= 1'b0;
        end
        S_ABSORB: if (in_hs) begin
          wc <= wc + 6'd1;
          if (in_last)               msg_done    <= 1'b1;
          if (short_last)            pad_started <= 1'b1;
          if (short_last && wc_last) pad_done    <= 1'b1;
        end
        S_PAD: begin
          wc          <= wc + 6'd1;
          pad_started <= 1'b1;
          if (wc_last) pad_done <= 1'b1;
        end
        S_ROTATE: wc <= wc + 6'd1;
        S_WAIT: if (core_done) begin
          wc <= '0;
          oc <= '0;
        end
        S_SQUEEZE: if (out_hs) begin
          if (oc == OUT_LAST) begin
            oc          <= '0;
            msg_done    <= 1'b0;
            pad_started <= 1'b0;
            pad_done    <= 1'b0;
          end else begin
            oc <= oc + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Absorb is always squeeze+absorb together; squeeze alone would overwrite the state.
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    core_init    = 1'b0;
    core_go      = 1'b0;
    core_absorb  = 1'b0;
    core_squeeze = 1'b0;
    core_extend  = 1'b0;
    core_din_0   = '0;
    core_din_1   = '0;
    case (state)
      S_INIT:   core_init = 1'b1;
      S_ABSORB: begin
        in_ready     = 1'b1;
        core_absorb  = in_hs;
        core_squeeze = in_hs;
        core_din_0   = in_data_0 ^ pad_mask;
        core_din_1   = in_data_1;
      end
      S_PAD: begin
        core_absorb  = 1'b1;
        core_squeeze = 1'b1;
        core_din_0   = (pad_started ? 32'h0 : {24'h0, DOMAIN}) |
                       (wc_last ? 32'h8000_0000 : 32'h0);
      end
      S_ROTATE:  core_extend = 1'b1;
      S_GO:      core_go = 1'b1;
      S_SQUEEZE: begin
        out_valid   = 1'b1;
        out_last    = (oc == OUT_LAST);
        core_extend = out_ready;
      end
      default: ;
    endcase
  end

  assign out_data_0 = core_result_0;
  assign out_data_1 = core_result_1;
  assign busy       = (state != S_IDLE);

endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
- Host-side initiator for the masked keccak1600 core.
- Accepts a two-share 32-bit message stream with valid/ready handshake and applies SHA-3 padding to share 0 only.
- Drives the core's init/absorb/squeeze/extend/go controls and word inputs, runs one permutation per rate block, then streams the two-share digest out.
- Sits between the bus/DMA front end and the core; the core's rand_data is fed separately.

Parameters:
- RATE_WORDS, 34, rate in 32-bit words (34 = SHA3-256); legal range 2..49.
- OUT_WORDS, 8, digest words squeezed; must be ≤ RATE_WORDS.
- DOMAIN, 8'h06, domain-separation/first padding byte.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  message word valid
- in_ready  out  1  message word accepted when in_valid & in_ready
- in_data_0  in  32  message share 0, little-endian (byte k = bits 8k+7:8k)
- in_data_1  in  32  message share 1
- in_last  in  1  final message word
- in_bytes  in  3  valid bytes of final word, 1..4; ignored unless in_last
- out_valid  out  1  digest word valid
- out_ready  in  1  digest word consumed when out_valid & out_ready
- out_data_0  out  32  digest share 0
- out_data_1  out  32  digest share 1
- out_last  out  1  final digest word
- busy  out  1  high in any state except IDLE
- core_init, core_go, core_absorb, core_squeeze, core_extend  out  1 each  core controls
- core_din_0, core_din_1  out  32  core word inputs
- core_done  in  1  core completion pulse
- core_result_0, core_result_1  in  32  core word outputs

Behaviour:
- Reset (async assert, sync release): state=IDLE, counters=0, pad flags=0. All outputs 0 while in IDLE except out_data = core_result passthrough. The core shares this reset; reset must span ≥1 clk edge.
- Core control encoding, all combinational from state and handshake; otherwise all 0:
  - absorb a word: squeeze=1, absorb=1, extend=0.
  - rotate: extend=1.
  - never squeeze=1 with absorb=0 (that overwrites the state).
- States:
  - IDLE: in_ready=0. If in_valid, go to INIT.
  - INIT: core_init=1 for one cycle (clears core state). wc=0. Go to ABSORB.
  - ABSORB: in_ready=1. On handshake, absorb din_0 = in_data_0 ^ padmask, din_1 = in_data_1, then wc++.
    - padmask: in_last & in_bytes<4 → DOMAIN<<(8·in_bytes), set pad_started. If also wc==RATE_WORDS-1, OR in 8'h80<<24.
    - in_last: set msg_done. If in_bytes==4, pad_started stays 0. If pad_started and the final 0x80 was placed, set pad_done.
    - Leave when wc reaches RATE_WORDS → ROTATE. Or when msg_done and not pad_done → PAD.
  - PAD: one word per cycle, no stall. din_0 = (pad_started ? 0 : DOMAIN) | (wc==RATE_WORDS-1 ? 32'h80000000 : 0), din_1 = 0. Set pad_started. At wc==RATE_WORDS-1 set pad_done. At wc==RATE_WORDS → ROTATE.
  - ROTATE: extend=1 for exactly 50-RATE_WORDS cycles, which restores alignment (first absorbed word lands at core bits 31:0). Then → GO.
  - GO: core_go=1 for one cycle. → WAIT.
  - WAIT: hold until core_done. Then wc=0; pad_done → SQUEEZE, else → ABSORB.
  - SQUEEZE: out_valid=1, out_data_x = core_result_x, core_extend = out_ready. oc counts handshakes; out_last when oc==OUT_WORDS-1. After the final handshake → IDLE, all flags cleared.
- Boundaries:
  - in_bytes==4 on last word with wc==RATE_WORDS-1 → a full extra padding block: ROTATE, permute, then PAD from wc=0.
  - in_bytes==3 on word RATE_WORDS-1 → single pad byte 0x86 at byte 3 (0x06<<24 | 0x80<<24).
  - in_valid is ignored outside ABSORB/IDLE.
  - No word is lost or duplicated under backpressure: out_ready low holds oc and core state.
  - Reset mid-operation → IDLE immediately; the message is discarded.
- Latency: permutation ≈ 49 cycles (24 × 2 + done) plus 50-RATE_WORDS rotate cycles plus 2 (GO, WAIT exit) per block.

Test Plan:
- "abc": one word, in_data_0 = 0x00636261^m, in_data_1 = m, in_bytes=3, in_last → share XOR out = a75d983a, b225e24f, 2d175c04, bd90d36b, 6e085f85, 5b529d3e, 45e2bf46, 32154311; out_last on the 8th word.
- Random mask m per word: recombined digest is identical to the unmasked run; share 1 alone is not equal to the digest.
- 136-byte message (34 full words, last in_bytes=4) → two permutations. Second block = 0x06 in word 0 and 0x80000000 in word 33. Digest matches the software model.
- 135-byte message (last word in_bytes=3 at wc=33) → single block with 0x86 byte. core_go pulsed exactly once.
- out_ready toggled randomly and in_valid gapped → same digest, core_extend only on handshake cycles, oc/wc never skip.
- Async reset asserted during WAIT → outputs 0 in the same cycle, busy=0. A following "abc" run gives the correct digest.
